// File: rtl/sd_cmd_serial_host.sv
// rtl/sd_cmd_serial_host.sv - SD CMD line bit-serial engine: sends a 48-bit command frame with CRC7,
// optionally captures and checks the card response, and reports status to the command master.
module sd_cmd_serial_host #(
  parameter int RESP_WAIT_MAX = 64,
  parameter int TX_FRAME_BITS = 48
) (
  input  logic        CLK_PAD_IO,
  input  logic        RST_PAD_I,
  input  logic [15:0] settings_in,
  input  logic [39:0] cmd_in,
  input  logic        req_in,
  input  logic        ack_in,
  output logic        ack_out,
  output logic        req_out,
  output logic [39:0] cmd_out,
  output logic [7:0]  serial_status,
  input  logic        cmd_dat_i,
  output logic        cmd_out_o,
  output logic        cmd_oe_o
);

  typedef enum logic [2:0] {
    IDLE, WRITE, TURN, WAIT_START, READ, REPORT, REPORT_WAIT
  } state_t;

  // size code: 0 = no response, 1 = 48-bit frame, 2 = 136-bit frame
  state_t      state_q, state_d;
  logic [39:0] tx_q, tx_d;
  logic [39:0] resp_q, resp_d;
  logic [6:0]  crc_q, crc_d;
  logic [6:0]  rx_crc_q, rx_crc_d;
  logic [7:0]  status_q, status_d;
  logic [7:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [2:0]  delay_q, delay_d;
  logic        crc_en_q, crc_en_d;
  logic [1:0]  size_q, size_d;
  logic        rdy_q, rdy_d;

  logic [1:0]  size_code;
  logic [7:0]  last_bit;
  logic        crc_ok;
  logic        unused_settings;

  assign unused_settings = ^settings_in[15:11];

  function automatic logic [6:0] crc_next(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  always_comb begin
    if (settings_in[6:0] == 7'd0)        size_code = 2'd0;
    else if (settings_in[6:0] == 7'd127) size_code = 2'd2;
    else                                 size_code = 2'd1;
  end

  assign last_bit = (size_q == 2'd2) ? 8'd135 : 8'd47;
  assign crc_ok   = (size_q == 2'd2) || !crc_en_q || (rx_crc_q == crc_q);

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    resp_d     = resp_q;
    crc_d      = crc_q;
    rx_crc_d   = rx_crc_q;
    status_d   = status_q;
    bit_cnt_d  = bit_cnt_q;
    wait_cnt_d = wait_cnt_q;
    delay_d    = delay_q;
    crc_en_d   = crc_en_q;
    size_d     = size_q;
    rdy_d      = 1'b1;
    case (state_q)
      IDLE: begin
        if (req_in) begin
          tx_d      = cmd_in;
          crc_d     = 7'd0;
          status_d  = 8'd0;
          delay_d   = settings_in[10:8];
          crc_en_d  = settings_in[7];
          size_d    = size_code;
          bit_cnt_d = 8'd0;
          state_d   = WRITE;
        end
      end
      WRITE: begin
        bit_cnt_d = bit_cnt_q + 8'd1;
        if (bit_cnt_q < 8'd40) begin
          tx_d  = {tx_q[38:0], 1'b0};
          crc_d = crc_next(crc_q, tx_q[39]);
        end else if (bit_cnt_q < 8'd47) begin
          crc_d = {crc_q[5:0], 1'b0};
        end
        if (bit_cnt_q == 8'(TX_FRAME_BITS - 1)) begin
          wait_cnt_d = 16'd0;
          crc_d      = 7'd0;
          if (size_q == 2'd0) begin
            status_d = 8'h60;
            state_d  = REPORT;
          end else begin
            state_d  = TURN;
          end
        end
      end
      TURN: begin
        if (wait_cnt_q == 16'(delay_q)) begin
          wait_cnt_d = 16'd0;
          state_d    = WAIT_START;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      WAIT_START: begin
        if (!cmd_dat_i) begin
          resp_d    = {resp_q[38:0], 1'b0};
          crc_d     = crc_next(crc_q, 1'b0);
          bit_cnt_d = 8'd1;
          state_d   = READ;
        end else if (wait_cnt_q == 16'(RESP_WAIT_MAX - 1)) begin
          status_d = 8'h80;
          state_d  = REPORT;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      READ: begin
        bit_cnt_d = bit_cnt_q + 8'd1;
        if (bit_cnt_q < 8'd40) begin
          resp_d = {resp_q[38:0], cmd_dat_i};
          crc_d  = crc_next(crc_q, cmd_dat_i);
        end else if (bit_cnt_q < 8'd47 && size_q == 2'd1) begin
          rx_crc_d = {rx_crc_q[5:0], cmd_dat_i};
        end
        if (bit_cnt_q == last_bit) begin
          status_d = {1'b0, 1'b1, crc_ok, !cmd_dat_i, 4'b0000};
          state_d  = REPORT;
        end
      end
      REPORT: begin
        if (ack_in) state_d = REPORT_WAIT;
      end
      REPORT_WAIT: begin
        if (!ack_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_PAD_IO) begin
    if (!RST_PAD_I) begin
      state_q    <= IDLE;
      tx_q       <= '0;
      resp_q     <= '0;
      crc_q      <= '0;
      rx_crc_q   <= '0;
      status_q   <= '0;
      bit_cnt_q  <= '0;
      wait_cnt_q <= '0;
      delay_q    <= '0;
      crc_en_q   <= 1'b0;
      size_q     <= '0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      resp_q     <= resp_d;
      crc_q      <= crc_d;
      rx_crc_q   <= rx_crc_d;
      status_q   <= status_d;
      bit_cnt_q  <= bit_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      delay_q    <= delay_d;
      crc_en_q   <= crc_en_d;
      size_q     <= size_d;
      rdy_q      <= rdy_d;
    end
  end

  // rdy_q keeps ack_out low for the cycle following reset
  assign ack_out       = (state_q == IDLE) && rdy_q;
  assign req_out       = (state_q == REPORT);
  assign cmd_out       = resp_q;
  assign serial_status = status_q;
  assign cmd_oe_o      = (state_q == WRITE);

  always_comb begin
    cmd_out_o = 1'b1;
    if (state_q == WRITE) begin
      if (bit_cnt_q < 8'd40)      cmd_out_o = tx_q[39];
      else if (bit_cnt_q < 8'd47) cmd_out_o = crc_q[6];
    end
  end

endmodule

// File: tb/tb_sd_cmd_serial_host.sv
// tb/tb_sd_cmd_serial_host.sv - directed and randomized self-checking bench for sd_cmd_serial_host.
module tb_sd_cmd_serial_host;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] settings_in = '0;
  logic [39:0] cmd_in = '0;
  logic        req_in = 1'b0;
  logic        ack_in = 1'b0;
  logic        ack_out;
  logic        req_out;
  logic [39:0] cmd_out;
  logic [7:0]  serial_status;
  logic        cmd_dat_i = 1'b1;
  logic        cmd_out_o;
  logic        cmd_oe_o;

  int checks = 0;
  int failures = 0;

  sd_cmd_serial_host #(.RESP_WAIT_MAX(64), .TX_FRAME_BITS(48)) dut (
    .CLK_PAD_IO(clk), .RST_PAD_I(rstn), .settings_in(settings_in), .cmd_in(cmd_in),
    .req_in(req_in), .ack_in(ack_in), .ack_out(ack_out), .req_out(req_out),
    .cmd_out(cmd_out), .serial_status(serial_status), .cmd_dat_i(cmd_dat_i),
    .cmd_out_o(cmd_out_o), .cmd_oe_o(cmd_oe_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // CRC7 as the remainder of (msg * x^7) divided by x^7+x^3+1
  function automatic logic [6:0] crc7_ref(input logic [39:0] m);
    logic [46:0] r;
    r = {m, 7'd0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r = r ^ (47'h89 << (i - 7));
    return r[6:0];
  endfunction

  task automatic wait_ack();
    int n = 0;
    while (ack_out !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("wait_ack_out", ack_out, 1'b1);
  endtask

  task automatic send(input logic [39:0] c, input logic [15:0] s, input string tag,
                      output logic [47:0] tx);
    logic oe_ok;
    wait_ack();
    cmd_in = c;
    settings_in = s;
    req_in = 1'b1;
    @(negedge clk);
    req_in = 1'b0;
    oe_ok = 1'b1;
    for (int i = 0; i < 48; i++) begin
      if (i > 0) @(negedge clk);
      tx[47 - i] = cmd_out_o;
      oe_ok = oe_ok & cmd_oe_o;
    end
    chk({tag, "_frame"}, tx, {c, crc7_ref(c), 1'b1});
    chk({tag, "_oe"}, oe_ok, 1'b1);
  endtask

  task automatic respond(input int idle, input int len, input logic [135:0] fr);
    for (int i = 0; i < idle + len; i++) begin
      cmd_dat_i = (i < idle) ? 1'b1 : fr[135 - (i - idle)];
      @(negedge clk);
    end
    cmd_dat_i = 1'b1;
  endtask

  task automatic finish_report(input logic [7:0] st, input logic [39:0] co, input bit check_co,
                               input int hold, input string tag);
    int n = 0;
    while (req_out !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_req_out"}, req_out, 1'b1);
    chk({tag, "_status"}, serial_status, st);
    if (check_co) chk({tag, "_cmd_out"}, cmd_out, co);
    ack_in = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_req_drop"}, req_out, 1'b0);
      chk({tag, "_ack_hold"}, ack_out, 1'b0);
    end
    ack_in = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_ack"}, ack_out, 1'b1);
  endtask

  initial begin
    logic [47:0]  tx;
    logic [135:0] fr;
    logic [39:0]  pay;
    logic [94:0]  filler;
    logic [15:0]  s;
    logic [6:0]   sz, rcrc;
    logic [7:0]   est;
    logic         endb, cv, crcen;
    int           d, len, idle;

    repeat (3) @(negedge clk);
    chk("rst_ack_out", ack_out, 1'b0);
    chk("rst_req_out", req_out, 1'b0);
    chk("rst_cmd_out", cmd_out, 40'd0);
    chk("rst_status", serial_status, 8'd0);
    chk("rst_line", {cmd_out_o, cmd_oe_o}, 2'b10);
    rstn = 1'b1;

    send(40'h4000000000, 16'h0000, "cmd0", tx);
    chk("cmd0_crc_byte", tx[7:0], 8'h95);
    finish_report(8'h60, 40'd0, 1'b0, 1, "cmd0");

    send(40'h48000001AA, 16'h02A8, "cmd8", tx);
    chk("cmd8_crc_byte", tx[7:0], 8'h87);
    respond(5, 48, {40'h48000001AA, 7'h43, 1'b1, 88'd0});
    finish_report(8'h60, 40'h48000001AA, 1'b1, 1, "cmd8");

    send(40'h48000001AA, 16'h02A8, "badcrc", tx);
    respond(5, 48, {40'h48000001AA, 7'h42, 1'b1, 88'd0});
    finish_report(8'h40, 40'h48000001AA, 1'b1, 1, "badcrc");

    send(40'h48000001AA, 16'h0228, "nocrc", tx);
    respond(5, 48, {40'h48000001AA, 7'h42, 1'b1, 88'd0});
    finish_report(8'h60, 40'h48000001AA, 1'b1, 1, "nocrc");

    // edges 0..d+1 cover WRITE end and TURN; WAIT_START spans edges d+2..d+65
    send(40'h4D00000000, 16'h03A8, "tmo", tx);
    cmd_dat_i = 1'b1;
    repeat (3 + 65) @(negedge clk);
    chk("tmo_req_early", req_out, 1'b0);
    @(negedge clk);
    chk("tmo_req_exact", req_out, 1'b1);
    chk("tmo_status_exact", serial_status, 8'h80);
    finish_report(8'h80, 40'd0, 1'b0, 1, "tmo");

    filler = 95'({$urandom(), $urandom(), $urandom()});
    send(40'h42000000FF, 16'h01FF, "long", tx);
    respond(4, 136, {40'h3F12345678, filler, 1'b0});
    finish_report(8'h70, 40'h3F12345678, 1'b1, 4, "long");

    wait_ack();
    cmd_in = 40'h4000000000;
    settings_in = 16'h0000;
    req_in = 1'b1;
    @(negedge clk);
    req_in = 1'b0;
    repeat (20) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("midrst_oe", cmd_oe_o, 1'b0);
    chk("midrst_ack_out", ack_out, 1'b0);
    chk("midrst_req_out", req_out, 1'b0);
    rstn = 1'b1;
    @(negedge clk);
    chk("midrst_release_ack", ack_out, 1'b1);
    send(40'h4C12345678, 16'h0000, "postrst", tx);
    finish_report(8'h60, 40'd0, 1'b0, 1, "postrst");

    for (int t = 0; t < 16; t++) begin
      d = int'($urandom_range(0, 7));
      crcen = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: sz = 7'd0;
        1: sz = 7'd40;
        2: sz = 7'd127;
        default: begin
          sz = 7'($urandom_range(1, 126));
          if (sz == 7'd40) sz = 7'd41;
        end
      endcase
      s = {3'b000, 2'($urandom), 3'(d), crcen, sz};
      pay = {1'b0, 7'($urandom), 32'($urandom)};
      send({2'b01, 6'($urandom), 32'($urandom)}, s, $sformatf("rnd%0d", t), tx);
      if (sz == 7'd0) begin
        finish_report(8'h60, 40'd0, 1'b0, 1, $sformatf("rnd%0d", t));
      end else if ($urandom_range(0, 5) == 0) begin
        respond(d + 66, 0, 136'd0);
        finish_report(8'h80, 40'd0, 1'b0, int'($urandom_range(1, 3)), $sformatf("rnd%0d", t));
      end else begin
        len = (sz == 7'd127) ? 136 : 48;
        endb = ($urandom_range(0, 3) != 0);
        rcrc = crc7_ref(pay);
        if ($urandom_range(0, 2) == 0) rcrc = rcrc ^ 7'($urandom_range(1, 127));
        filler = 95'({$urandom(), $urandom(), $urandom()});
        fr = (len == 48) ? {pay, rcrc, endb, 88'd0} : {pay, filler, endb};
        cv = (len == 136) || !crcen || (rcrc == crc7_ref(pay));
        est = {1'b0, 1'b1, cv, !endb, 4'b0000};
        idle = d + 2 + int'($urandom_range(0, 10));
        respond(idle, len, fr);
        finish_report(est, pay, 1'b1, int'($urandom_range(1, 3)), $sformatf("rnd%0d", t));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
